// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: 4-requester byte arbiter feeding a single uart_tx.
// Default build uses round-robin arbitration; define UART_ARB_FIXED_PRIO_EN for fixed priority (0 highest).
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_enabled,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;
    state_t      state, state_nx;
    logic        rdy_m, rdy_s;
    logic [15:0] cnt;
    logic [1:0]  win;
    logic        grant, tmo;
    // tx_ready comes from the baud domain, so bring it in through two flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= tx_ready;
            rdy_s <= rdy_m;
        end
    end
`ifdef UART_ARB_FIXED_PRIO_EN
    // lowest-numbered valid requester wins
    always_comb begin
        win = 2'd0;
        for (int i = 3; i >= 0; i--) if (req_valid[i]) win = 2'(i);
    end
`else
    logic [1:0] last_grant;
    // search from last_grant+1 upward with wrap; descending loop so the nearest valid requester is written last
    always_comb begin
        win = 2'd0;
        for (int k = 4; k >= 1; k--) if (req_valid[last_grant + 2'(k)]) win = last_grant + 2'(k);
    end
    // round-robin pointer moves only when a byte is actually accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= 2'd3;
        else if (grant) last_grant <= win;
    end
`endif
    assign grant = (state == IDLE) && rdy_s && (|req_valid);
    assign tmo   = (state == LAUNCH) && rdy_s && (cnt == 16'(TIMEOUT_CYCLES - 1));
    assign busy  = (state != IDLE);
    // next-state and Moore/grant outputs
    always_comb begin
        state_nx   = state;
        req_ready  = 4'b0000;
        tx_enabled = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    req_ready[win] = 1'b1;
                    state_nx       = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_enabled = 1'b1;
                state_nx   = !rdy_s ? WAIT_DONE : tmo ? IDLE : LAUNCH;
            end
            WAIT_DONE: state_nx = rdy_s ? IDLE : WAIT_DONE;
            default:   state_nx = IDLE;
        endcase
    end
    // state register, launch timer, granted byte capture and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            tx_data     <= 8'h00;
            grant_id    <= 2'd0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state == LAUNCH) ? cnt + 16'd1 : 16'd0;
            if (grant) begin
                tx_data  <= req_data[{win, 3'b000} +: 8];
                grant_id <= win;
            end
            if (tmo) timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a simple uart_tx model.
module tb_uart_tx_arbiter;
    localparam int TMO = 8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h44332211;
    logic [3:0]  req_ready;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_enabled;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;
    logic        tx_mode = 1'b0;
    logic        tx_force = 1'b0;
    logic        auto_rdy = 1'b1;
    int          busy_cnt = 0;
    typedef struct {logic [1:0] id; logic [7:0] data;} exp_t;
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          grants = 0;
    logic [1:0]  mdl_last = 2'd3;
    logic        post = 1'b0;
    logic [1:0]  exp_id;
    logic [7:0]  exp_byte;
    int          n;
    uart_tx_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_enabled(tx_enabled), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );
    assign tx_ready = tx_mode ? auto_rdy : tx_force;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic push_exp(input logic [3:0] v);
        logic [1:0] r = 2'd0;
        logic [1:0] idx;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
`else
        for (int k = 4; k >= 1; k--) begin
            idx = mdl_last + 2'(k);
            if (v[idx]) r = idx;
        end
        mdl_last = r;
`endif
        idx = 2'(idx);
        sb.push_back('{id: r, data: req_data[8*r +: 8]});
    endtask
    task automatic wait_grants(input int target);
        int w = 0;
        while (grants < target && w < 300) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("grant_reached", 32'(grants >= target), 1);
    endtask
    task automatic wait_idle();
        int w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (busy && w < 300);
        check("idle_reached", 32'(busy), 0);
    endtask
    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_tx_enabled", 32'(tx_enabled), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
    endtask
    always @(negedge clk) begin
        if (!tx_mode) begin
            auto_rdy = 1'b1;
            busy_cnt = 0;
        end else if (tx_enabled && auto_rdy) begin
            auto_rdy = 1'b0;
            busy_cnt = 10;
        end else if (!auto_rdy) begin
            if (busy_cnt == 0) auto_rdy = 1'b1;
            else busy_cnt--;
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (post) begin
            check("tx_data", 32'(tx_data), 32'(exp_byte));
            check("grant_id", 32'(grant_id), 32'(exp_id));
            check("tx_enabled_launch", 32'(tx_enabled), 1);
            post = 1'b0;
        end
        if (req_ready != 4'b0000) begin
            grants++;
            if (sb.size() == 0) begin
                check("unexpected_grant", 32'(req_ready), 0);
            end else begin
                e = sb.pop_front();
                check("req_ready", 32'(req_ready), 32'(4'b0001 << e.id));
                exp_byte = e.data;
                exp_id   = e.id;
                post     = 1'b1;
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        push_exp(req_valid);
        repeat (20) @(negedge clk);
        #1;
        check("no_grant_tx_low", 32'(grants), 0);
        tx_force = 1'b1;
        n = 0;
        while (grants == 0 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ready_latency", 32'(n), 2);
        tx_mode = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_idle();
        req_data[23:16] = 8'hA5;
        req_valid = 4'b0100;
        push_exp(req_valid);
        wait_grants(2);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_idle();
        req_valid = 4'b0010;
        push_exp(req_valid);
        wait_grants(3);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        n = 0;
        while (!(busy && !tx_enabled) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_wait_done", 32'(busy && !tx_enabled), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        mdl_last = 2'd3;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1111;
        repeat (5) push_exp(4'b1111);
        wait_grants(8);
        @(posedge clk);
        #1;
        req_valid = 4'b1010;
        repeat (3) push_exp(4'b1010);
        wait_grants(11);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        wait_idle();
        tx_mode = 1'b0;
        tx_force = 1'b1;
        req_valid = 4'b0001;
        push_exp(req_valid);
        wait_grants(12);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        n = 0;
        @(negedge clk);
        #1;
        while (tx_enabled && n < 30) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("timeout_launch_len", 32'(n), TMO);
        check("timeout_err_set", 32'(timeout_err), 1);
        check("timeout_back_idle", 32'(busy), 0);
        req_valid = 4'b1000;
        push_exp(req_valid);
        wait_grants(13);
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        tx_mode = 1'b1;
        wait_idle();
        check("timeout_err_sticky", 32'(timeout_err), 1);
        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
